// File: rtl/risc_sequencer_if.sv
// Datapath-side bundle for the VeriRisc phase sequencer: decoded IR/flag inputs,
// control strobes and debug/status outputs.
interface risc_sequencer_if #(
  parameter int ICNT_W = 16
);
  logic [2:0]        opcode;
  logic              zero;
  logic              sel;
  logic              rd;
  logic              ld_ir;
  logic              inc_pc;
  logic              ld_pc;
  logic              ld_ac;
  logic              wr;
  logic              data_e;
  logic              halt;
  logic [2:0]        phase;
  logic [ICNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, instr_cnt
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, instr_cnt
  );
endinterface

// File: rtl/risc_sequencer.sv
// VeriRisc 8-phase sequencer / control decoder with halt state and a saturating retired-instruction count.
// Optional macro RISC_SEQ_RESUME_EN adds a `resume` input that restarts from the halted state.
module risc_sequencer #(
  parameter int ICNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef RISC_SEQ_RESUME_EN
  input  logic                resume,
`endif
  risc_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  function automatic logic [ICNT_W-1:0] sat_inc(input logic [ICNT_W-1:0] v);
    return (&v) ? v : v + ICNT_W'(1);
  endfunction

  phase_e            phase_q, phase_d;
  logic              halted_q, halted_d;
  logic [ICNT_W-1:0] cnt_q, cnt_d;
  logic              resume_req;
  logic              aluop;
  logic              is_hlt, is_skz, is_sto, is_jmp;

`ifdef RISC_SEQ_RESUME_EN
  assign resume_req = resume;
`else
  assign resume_req = 1'b0;
`endif

  assign is_hlt = (bus.opcode == OP_HLT);
  assign is_skz = (bus.opcode == OP_SKZ);
  assign is_sto = (bus.opcode == OP_STO);
  assign is_jmp = (bus.opcode == OP_JMP);
  assign aluop  = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    halted_d    = halted_q;
    cnt_d       = cnt_q;
    bus.sel     = 1'b0;
    bus.rd      = 1'b0;
    bus.ld_ir   = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.ld_pc   = 1'b0;
    bus.ld_ac   = 1'b0;
    bus.wr      = 1'b0;
    bus.data_e  = 1'b0;
    bus.halt    = 1'b0;

    if (halted_q) begin
      bus.halt = 1'b1;
      // Resume skips the HLT's own operand phase; PC advances past the HLT now.
      if (resume_req) begin
        bus.inc_pc = 1'b1;
        halted_d   = 1'b0;
        phase_d    = OP_FETCH;
      end
    end else begin
      phase_d = phase_e'(phase_q + 3'd1);
      unique case (phase_q)
        INST_ADDR: begin
          bus.sel = 1'b1;
        end
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          if (is_hlt) begin
            bus.halt = 1'b1;
            halted_d = 1'b1;
            phase_d  = phase_q;
          end else begin
            bus.inc_pc = 1'b1;
          end
        end
        OP_FETCH: begin
          bus.rd = aluop;
        end
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = is_skz && bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.ld_pc  = is_jmp;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
          // A resumed HLT reaches here with opcode still HLT and must not count.
          if (!is_hlt) cnt_d = sat_inc(cnt_q);
        end
        default: begin
          phase_d = INST_ADDR;
        end
      endcase
    end
  end

  assign bus.phase     = phase_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Randomized self-checking bench for risc_sequencer against an instruction-level reference model.
module tb_risc_sequencer;
  localparam int ICNT_W = 4;
`ifdef RISC_SEQ_RESUME_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDI = 3'd3,
                         XORI = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resume = 1'b0;

  risc_sequencer_if #(.ICNT_W(ICNT_W)) bus ();

  risc_sequencer #(.ICNT_W(ICNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef RISC_SEQ_RESUME_EN
    .resume (resume),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position within the 8-clock instruction, halt flag, retired count.
  int m_phase = 0;
  int m_cnt = 0;
  bit m_halted = 1'b0;
  bit m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
  function automatic logic [8:0] exp_strobes(input int ph, input bit hl,
                                             input logic [2:0] op, input logic z, input logic res);
    bit alu;
    logic [8:0] s;
    alu = (op == ADD) || (op == ANDI) || (op == XORI) || (op == LDA);
    s = '0;
    if (hl) begin
      s[0] = 1'b1;
      s[5] = RES_EN && res;
    end else if (ph <= 3) begin
      s[8] = 1'b1;
      s[7] = (ph >= 1);
      s[6] = (ph >= 2);
    end else if (ph == 4) begin
      s[0] = (op == HLT);
      s[5] = (op != HLT);
    end else begin
      s[7] = alu;
      s[5] = (ph == 6) && (op == SKZ) && z;
      s[4] = (ph >= 6) && (op == JMP);
      s[3] = (ph == 7) && alu;
      s[2] = (ph == 7) && (op == STO);
      s[1] = (ph >= 6) && (op == STO);
    end
    return s;
  endfunction

  task automatic cyc(input logic r, input logic [2:0] op, input logic z, input logic res);
    logic [8:0] e;
    @(negedge clk);
    rst = r;
    bus.opcode = op;
    bus.zero = z;
    resume = res;
    #1;
    if (m_known) begin
      e = exp_strobes(m_phase, m_halted, op, z, res);
      check("sel", bus.sel, e[8]);
      check("rd", bus.rd, e[7]);
      check("ld_ir", bus.ld_ir, e[6]);
      check("inc_pc", bus.inc_pc, e[5]);
      check("ld_pc", bus.ld_pc, e[4]);
      check("ld_ac", bus.ld_ac, e[3]);
      check("wr", bus.wr, e[2]);
      check("data_e", bus.data_e, e[1]);
      check("halt", bus.halt, e[0]);
      check("phase", bus.phase, m_phase);
      check("instr_cnt", bus.instr_cnt, m_cnt);
    end
    if (r) begin
      m_phase = 0;
      m_halted = 1'b0;
      m_cnt = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (m_halted) begin
        if (RES_EN && res) begin
          m_halted = 1'b0;
          m_phase = 5;
        end
      end else if (m_phase == 4 && op == HLT) begin
        m_halted = 1'b1;
      end else begin
        if (m_phase == 7 && op != HLT && m_cnt < (1 << ICNT_W) - 1) m_cnt++;
        m_phase = (m_phase + 1) % 8;
      end
    end
  endtask

  task automatic run(input logic [2:0] op, input logic z, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, op, z, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, HLT, 1'b0, 1'b0);
    cyc(1'b0, HLT, 1'b0, 1'b0);
  endtask

  logic [2:0] cur_op;

  initial begin
    bus.opcode = HLT;
    bus.zero = 1'b0;

    // Reset with HLT, then HLT as first instruction
    do_reset();
    cyc(1'b0, HLT, 1'b0, 1'b0);
    check("rst_phase", bus.phase, 1);
    check("rst_halt", bus.halt, 0);
    check("rst_sel", bus.sel, 1);
    check("rst_cnt", bus.instr_cnt, 0);
    run(HLT, 1'b0, 2);
    check("hlt_p3_halt", bus.halt, 0);
    check("hlt_p3_phase", bus.phase, 3);
    run(HLT, 1'b0, 1);
    check("hlt_p4_halt", bus.halt, 1);
    check("hlt_p4_inc", bus.inc_pc, 0);
    run(HLT, 1'b0, 5);
    check("hlt_hold_phase", bus.phase, 4);
    check("hlt_hold_halt", bus.halt, 1);

    // JMP then HLT
    do_reset();
    run(JMP, 1'b0, 8);
    run(HLT, 1'b0, 4);
    check("jmp_hlt_halt", bus.halt, 1);
    check("jmp_hlt_cnt", bus.instr_cnt, 1);

    // SKZ both ways, STO, LDA (model checks every strobe every cycle)
    do_reset();
    run(SKZ, 1'b1, 8);
    run(SKZ, 1'b0, 8);
    run(STO, 1'b0, 8);
    run(LDA, 1'b1, 8);
    check("mix_cnt", bus.instr_cnt, 4);

    // Reset in phase 6 of a JMP
    run(JMP, 1'b0, 6);
    check("mid_phase6", bus.phase, 6);
    cyc(1'b1, JMP, 1'b0, 1'b0);
    cyc(1'b0, JMP, 1'b0, 1'b0);
    check("mid_rst_phase", bus.phase, 0);
    check("mid_rst_ldpc", bus.ld_pc, 0);
    check("mid_rst_cnt", bus.instr_cnt, 0);

`ifdef RISC_SEQ_RESUME_EN
    run(ADD, 1'b0, 7);
    run(HLT, 1'b0, 7);
    cyc(1'b0, HLT, 1'b0, 1'b1);
    check("resume_inc", bus.inc_pc, 1);
    cyc(1'b0, HLT, 1'b0, 1'b0);
    check("resume_p5", bus.phase, 5);
    check("resume_halt", bus.halt, 0);
    run(HLT, 1'b0, 3);
    check("resume_p0", bus.phase, 0);
    check("resume_cnt", bus.instr_cnt, 1);
`endif

    // Saturation of the retired-instruction counter
    do_reset();
    run(ADD, 1'b0, 8 * ((1 << ICNT_W) + 3));
    check("sat_cnt", bus.instr_cnt, (1 << ICNT_W) - 1);

    // Randomized instruction stream with sporadic reset and resume
    cur_op = ADD;
    for (int i = 0; i < 4000; i++) begin
      logic r, z, res;
      logic [2:0] op;
      r = ($urandom_range(0, 59) == 0);
      z = 1'($urandom_range(0, 1));
      res = ($urandom_range(0, 3) == 0);
      if (m_halted) op = HLT;
      else if (m_phase < 3) op = 3'($urandom_range(0, 7));
      else begin
        if (m_phase == 3)
          cur_op = ($urandom_range(0, 7) == 0) ? HLT : 3'($urandom_range(1, 7));
        op = cur_op;
      end
      cyc(r, op, z, res);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
